seg7_scan_driver: RTL

//  Consumes the hundreds/tens/ones BCD digits from the binary-to-BCD stage.

---
 rtl/seg7_scan_driver_pkg.sv | 53 +++++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 36 +++
 rtl/seg7_scan_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared definitions for the 3-digit 7-segment scan driver:
//   - active-high segment codes {g,f,e,d,c,b,a} for the digits 0..9, the
//     dash shown for non-BCD input, and the all-off pattern
//   - digit-slot state encoding for the scan FSM
//   - packed triple of BCD digits used for the holding and display registers
//   - helper mapping a slot to its active-high anode one-hot
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    // Segment codes, active-high, bit 0 = segment a.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan order is ones -> tens -> hundreds -> ones.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,   // ones
        DIG1 = 2'd1,   // tens
        DIG2 = 2'd2    // hundreds
    } slot_t;

    // One full display value; field order matches the numeric weight.
    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } digits_t;

    // Active-high anode pattern for a slot: an[0]=ones, an[1]=tens, an[2]=hundreds.
    function automatic logic [2:0] slot_onehot(input slot_t s);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (s)
            DIG0:    oh = 3'b001;
            DIG1:    oh = 3'b010;
            DIG2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
//   Combinational 4-bit BCD to 7-segment decoder, active-high output.
//   Codes 10..15 are not BCD and decode to a dash so a bad upstream value is
//   visible on the display instead of looking like a plausible number.
// Ports
//   digit  in  4  BCD digit
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every path of a combinational block must assign every output;
        // the default first assignment guarantees that and prevents a latch.
        seg = SEG_DASH;
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a 3-digit 7-segment display.
//   Digits are captured into holding registers on an update strobe and copied
//   to the display registers only when the hundreds slot ends, so one frame
//   always shows a single consistent value. Leading zeros can be blanked, and
//   each slot starts with GHOST_CYC cycles of all anodes off so the previous
//   digit's segment pattern never bleeds into the next digit.
// Parameters
//   CLK_HZ, SCAN_HZ  slot length DIV = CLK_HZ/SCAN_HZ cycles (DIV >= 4)
//   GHOST_CYC        anode-off cycles at slot start (GHOST_CYC < DIV)
//   LZB              1 = blank leading zeros
//   SEG_ACT_LOW      1 = segment outputs active-low
//   AN_ACT_LOW       1 = anode outputs active-low
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   update      in   1  strobe: capture hundreds/tens/ones
//   hundreds    in   4  BCD digit 2
//   tens        in   4  BCD digit 1
//   ones        in   4  BCD digit 0
//   blank       in   1  forces all anodes inactive while high
//   seg         out  7  segments {g,f,e,d,c,b,a}, registered
//   an          out  3  anodes, an[0]=ones .. an[2]=hundreds, registered
//   frame_done  out  1  pulse on the cycle the hundreds slot ends
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int GHOST_CYC   = 16,
    parameter bit LZB         = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);

    // XOR masks turning the active-high internal view into pin polarity.
    localparam logic [6:0] SEG_POL = {7{SEG_ACT_LOW}};
    localparam logic [2:0] AN_POL  = {3{AN_ACT_LOW}};

    // -------------------------------------------------------------------------
    // Slot prescaler: one tick every DIV cycles
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Slot FSM: state register / next-state logic / output logic
    // -------------------------------------------------------------------------
    slot_t slot;
    slot_t slot_next;
    logic  frame_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= DIG0;
        end else begin
            slot <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot;
        if (tick) begin
            unique case (slot)
                DIG0:    slot_next = DIG1;
                DIG1:    slot_next = DIG2;
                DIG2:    slot_next = DIG0;
                default: slot_next = DIG0;
            endcase
        end
    end

    // The frame ends on the last cycle of the hundreds slot; that same cycle
    // commits the holding registers and is flagged on frame_done.
    always_comb begin
        frame_wrap = tick && (slot == DIG2);
    end

    assign frame_done = frame_wrap;

    // -------------------------------------------------------------------------
    // Holding and display registers
    // -------------------------------------------------------------------------
    digits_t hold;
    digits_t disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (update) begin
            hold <= '{hundreds: hundreds, tens: tens, ones: ones};
        end
    end

    // Reads the pre-edge holding value, so an update landing on the wrap
    // cycle is deferred to the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp <= '0;
        end else if (frame_wrap) begin
            disp <= hold;
        end
    end

    // -------------------------------------------------------------------------
    // Digit selection, leading-zero blanking and decode
    // -------------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic       cur_dark;
    logic       hund_zero;
    logic       tens_zero;
    logic [6:0] cur_code;

    // A non-BCD digit is nonzero here, so it is never blanked and its dash shows.
    assign hund_zero = (disp.hundreds == 4'd0);
    assign tens_zero = (disp.tens == 4'd0);

    always_comb begin
        cur_digit = disp.ones;
        cur_dark  = 1'b0;
        unique case (slot)
            DIG0: begin
                cur_digit = disp.ones;
                cur_dark  = 1'b0;
            end
            DIG1: begin
                cur_digit = disp.tens;
                cur_dark  = LZB && hund_zero && tens_zero;
            end
            DIG2: begin
                cur_digit = disp.hundreds;
                cur_dark  = LZB && hund_zero;
            end
            default: begin
                cur_digit = disp.ones;
                cur_dark  = 1'b1;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (cur_code)
    );

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic       an_on;
    logic [2:0] an_next;
    logic [6:0] seg_next;

    // Segments are driven only while an anode is on, so a dark slot or the
    // ghost window presents a fully quiet display.
    always_comb begin
        an_on    = (cnt >= CNT_GHOST) && !blank && !cur_dark;
        an_next  = 3'b000;
        seg_next = SEG_OFF;
        if (an_on) begin
            an_next  = slot_onehot(slot);
            seg_next = cur_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF ^ SEG_POL;
            an  <= 3'b000 ^ AN_POL;
        end else begin
            seg <= seg_next ^ SEG_POL;
            an  <= an_next ^ AN_POL;
        end
    end

endmodule
